hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It works alongside the forwarding logic and resolves the hazards forwarding cannot cover: load-use stalls, ID-stage branch flushes and multi-cycle data-memory waits. It drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps saturating stall/flush statistics and a memory-timeout error flag.

---
 rtl/hazard_stall_controller.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Brief    : Pipeline stall/flush sequencer for load-use, ID-branch and
//            data-memory wait hazards, with saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             ID_BranchTaken_i,
    input  logic             MEM_Req_i,
    input  logic             MEM_Ack_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Write_o,
    output logic             ID_EX_Bubble_o,
    output logic             EX_MEM_Write_o,
    output logic             MEM_WB_Bubble_o,
    output logic             Mem_Err_o,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output logic [CNT_W-1:0] Flush_Cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [15:0]      c_WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_nxt;
    logic [15:0]      w_wait_inc;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_freeze;
    logic w_loaduse;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_write;
    logic w_id_ex_bubble;
    logic w_ex_mem_write;
    logic w_mem_wb_bubble;

    assign w_freeze  = ((r_state == S_RUN) && MEM_Req_i && !MEM_Ack_i)
                     || ((r_state == S_MEM_WAIT) && !MEM_Ack_i)
                     || (r_state == S_ERR);

    assign w_loaduse = EX_MemRead_i && (EX_Rd_i != 5'd0)
                     && ((EX_Rd_i == ID_rs1_i) || (EX_Rd_i == ID_rs2_i));

    assign w_wait_inc = r_wait_cnt + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (MEM_Req_i && !MEM_Ack_i) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_wait_nxt  = 16'd0;
                end
            end
            S_MEM_WAIT: begin
                if (MEM_Ack_i) begin
                    w_state_nxt = S_RUN;
                end else begin
                    // The RUN cycle that issued the request counts as the first
                    // frozen cycle, so ERR follows exactly TIMEOUT frozen cycles.
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc == c_WAIT_LAST) begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = 16'd0;
            end
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_write   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_write  = 1'b0;
        w_mem_wb_bubble = 1'b0;
        // Everything stays quiet while reset is held, independent of the clock.
        if (rst_i) begin
            if (w_freeze) begin
                w_mem_wb_bubble = 1'b1;
            end else if (w_loaduse) begin
                w_id_ex_write  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_ex_mem_write = 1'b1;
            end else begin
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
                w_if_id_flush  = ID_BranchTaken_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 16'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= (w_state_nxt == S_ERR);
            if ((w_freeze || w_loaduse) && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_if_id_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign PC_Write_o      = w_pc_write;
    assign IF_ID_Write_o   = w_if_id_write;
    assign IF_ID_Flush_o   = w_if_id_flush;
    assign ID_EX_Write_o   = w_id_ex_write;
    assign ID_EX_Bubble_o  = w_id_ex_bubble;
    assign EX_MEM_Write_o  = w_ex_mem_write;
    assign MEM_WB_Bubble_o = w_mem_wb_bubble;
    assign Mem_Err_o       = r_mem_err;
    assign Stall_Cnt_o     = r_stall_cnt;
    assign Flush_Cnt_o     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Brief    : Directed-vector scoreboard bench for hazard_stall_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    // Control bundle order: PC_W, IFID_W, IFID_FL, IDEX_W, IDEX_BUB, EXMEM_W, MEMWB_BUB
    localparam logic [6:0] c_RST  = 7'b0000000;
    localparam logic [6:0] c_NORM = 7'b1101010;
    localparam logic [6:0] c_FRZ  = 7'b0000001;
    localparam logic [6:0] c_LU   = 7'b0001110;
    localparam logic [6:0] c_FL   = 7'b1111010;

    typedef struct packed {
        int         id;
        logic [6:0] ctrl;
        logic       err;
        logic [3:0] st;
        logic [3:0] fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, req, ack;
    logic       pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, merr;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vid     = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .TIMEOUT (4),
        .CNT_W   (4)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .ID_rs1_i         (rs1),
        .ID_rs2_i         (rs2),
        .EX_MemRead_i     (mr),
        .EX_Rd_i          (rd),
        .ID_BranchTaken_i (br),
        .MEM_Req_i        (req),
        .MEM_Ack_i        (ack),
        .PC_Write_o       (pc_w),
        .IF_ID_Write_o    (ifid_w),
        .IF_ID_Flush_o    (ifid_f),
        .ID_EX_Write_o    (idex_w),
        .ID_EX_Bubble_o   (idex_b),
        .EX_MEM_Write_o   (exmem_w),
        .MEM_WB_Bubble_o  (memwb_b),
        .Mem_Err_o        (merr),
        .Stall_Cnt_o      (stall_cnt),
        .Flush_Cnt_o      (flush_cnt)
    );

    task automatic vec(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic m, input logic [4:0] d, input logic b,
                       input logic q, input logic k, input logic [6:0] ec,
                       input logic ee, input logic [3:0] es, input logic [3:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; rs1 = a1; rs2 = a2; mr = m; rd = d; br = b; req = q; ack = k;
        e.id = vid; e.ctrl = ec; e.err = ee; e.st = es; e.fl = ef;
        sb.push_back(e);
        vid++;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b};
            n_tests++;
            if (act !== e.ctrl || merr !== e.err || stall_cnt !== e.st || flush_cnt !== e.fl) begin
                n_fail++;
                $display("FAIL vec%0d: ctrl=%b err=%b stall=%0d flush=%0d, expected ctrl=%b err=%b stall=%0d flush=%0d",
                         e.id, act, merr, stall_cnt, flush_cnt, e.ctrl, e.err, e.st, e.fl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rs1 = '0; rs2 = '0; rd = '0; mr = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
        //  rst  rs1    rs2    mr    rd     br    req   ack   ctrl    err   stall  flush
        vec(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_RST,  1'b0, 4'd0, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd0, 4'd0);
        // Load-use via rs2, then x0 destination, then via rs1
        vec(1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, c_LU,   1'b0, 4'd0, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd1, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd1, 4'd0);
        vec(1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, c_LU,   1'b0, 4'd1, 4'd0);
        // Branch deferred by load-use, then flushed
        vec(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, c_LU,   1'b0, 4'd2, 4'd0);
        vec(1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, c_FL,   1'b0, 4'd3, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd3, 4'd1);
        vec(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd3, 4'd1);
        // Memory wait acked after 3 cycles
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd3, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd4, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd5, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, c_NORM, 1'b0, 4'd6, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd6, 4'd1);
        // First-cycle ack costs nothing
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, c_NORM, 1'b0, 4'd6, 4'd1);
        // Freeze beats load-use and branch; load-use resurfaces on the ack cycle
        vec(1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd6, 4'd1);
        vec(1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, c_LU,   1'b0, 4'd7, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, c_FL,   1'b0, 4'd8, 4'd1);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd8, 4'd2);
        // Timeout (TIMEOUT=4): four frozen cycles, then sticky ERR until reset
        vec(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_RST,  1'b0, 4'd0, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd0, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd1, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd2, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b0, 4'd3, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_FRZ,  1'b1, 4'd4, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, c_FRZ,  1'b1, 4'd5, 4'd0);
        vec(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_RST,  1'b0, 4'd0, 4'd0);
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd0, 4'd0);
        // Stall counter saturation at 15
        for (int i = 0; i < 20; i++) begin
            vec(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, c_LU, 1'b0,
                (i > 15) ? 4'd15 : 4'(i), 4'd0);
        end
        vec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_NORM, 1'b0, 4'd15, 4'd0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
